// File: rtl/bus_arbiter_if.sv
// Bus request/grant bundle between the unit bus controllers and the central arbiter.
// The master side drives requests and the slave side (the arbiter) returns grants.
interface bus_arbiter_if #(
  parameter int N_MASTERS = 3
);
  logic [N_MASTERS-1:0] br;
  logic [N_MASTERS-1:0] bg;
  logic [2:0]           grant_id;
  logic                 bus_busy;
  logic                 timeout;

  modport master (
    output br,
    input  bg,
    input  grant_id,
    input  bus_busy,
    input  timeout
  );

  modport slave (
    input  br,
    output bg,
    output grant_id,
    output bus_busy,
    output timeout
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin system bus arbiter with a tenure limit and idle turnaround between owners.
// All bus-side outputs are driven directly from flops.
//
//   state | meaning
//   IDLE  | no owner; grant the first requester at or after ptr
//   GRANT | owner holds bg; watch for release or tenure expiry
//   TURN  | forced bg=0 for TURN_CYCLES cycles before re-arbitrating
module bus_arbiter #(
  parameter int N_MASTERS   = 3,
  parameter int MAX_TENURE  = 64,
  parameter int TURN_CYCLES = 1
) (
  input logic         bus_clk,
  input logic         rst,
  bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] cnt;
  logic [1:0] turn_cnt;

  logic       win_found;
  logic [2:0] win_id;
  logic       owner_req;
  logic       tenure_hit;
  logic [2:0] next_ptr;

  // Search offsets ptr, ptr+1, ... and take the first active request.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (!win_found && bus.br[i] &&
            (i == int'(ptr) + k || i == int'(ptr) + k - N_MASTERS)) begin
          win_found = 1'b1;
          win_id    = 3'(i);
        end
      end
    end
  end

  // bg is one-hot on the owner, so masking br with it picks the owner's request.
  assign owner_req  = |(bus.bg & bus.br);
  assign tenure_hit = (MAX_TENURE != 0) && (cnt == 8'(MAX_TENURE));
  assign next_ptr   = (bus.grant_id == 3'(N_MASTERS - 1)) ? 3'd0 : bus.grant_id + 3'd1;

  always_ff @(posedge bus_clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= '0;
      cnt          <= '0;
      turn_cnt     <= '0;
      bus.bg       <= '0;
      bus.grant_id <= '0;
      bus.bus_busy <= 1'b0;
      bus.timeout  <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            bus.bg       <= N_MASTERS'(1) << win_id;
            bus.grant_id <= win_id;
            bus.bus_busy <= 1'b1;
            cnt          <= 8'd1;
            state        <= GRANT;
          end
        end
        GRANT: begin
          if (!owner_req || tenure_hit) begin
            bus.bg       <= '0;
            bus.bus_busy <= 1'b0;
            ptr          <= next_ptr;
            // A voluntary release in the expiry cycle wins, so no timeout then.
            bus.timeout  <= owner_req;
            turn_cnt     <= 2'(TURN_CYCLES - 1);
            state        <= (TURN_CYCLES == 0) ? IDLE : TURN;
          end else if (cnt != 8'hff) begin
            cnt <= cnt + 8'd1;
          end
        end
        TURN: begin
          if (turn_cnt == 2'd0) state <= IDLE;
          else turn_cnt <= turn_cnt - 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: N_MASTERS=3, MAX_TENURE=8, TURN_CYCLES=1.
// Each task drives one scenario and checks against hand-computed grants.
module tb_bus_arbiter;

  logic bus_clk;
  logic rst;
  int   n_pass;
  int   n_total;

  logic [2:0] br_q;
  logic       rst_q;

  bus_arbiter_if #(.N_MASTERS(3)) bus ();

  bus_arbiter #(
    .N_MASTERS  (3),
    .MAX_TENURE (8),
    .TURN_CYCLES(1)
  ) dut (
    .bus_clk(bus_clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  task automatic tick();
    @(posedge bus_clk);
    @(negedge bus_clk);
  endtask

  task automatic do_reset(input logic [2:0] br_v);
    @(negedge bus_clk);
    rst    = 1'b0;
    bus.br = br_v;
    @(negedge bus_clk);
    rst = 1'b1;
  endtask

  // Per-cycle invariants: one-hot grant, granted only to a sampled requester, busy tracks bg.
  always @(posedge bus_clk) begin
    br_q  <= bus.br;
    rst_q <= rst;
  end

  always @(negedge bus_clk) begin
    if (rst === 1'b1 && rst_q === 1'b1) begin
      n_total++;
      if (!$onehot0(bus.bg)) $display("FAIL onehot0 bg=%b", bus.bg);
      else n_pass++;
      n_total++;
      if ((bus.bg & ~br_q) !== 3'b000) $display("FAIL bg_subset bg=%b prev_br=%b", bus.bg, br_q);
      else n_pass++;
      n_total++;
      if (bus.bus_busy !== (|bus.bg)) $display("FAIL busy_vs_bg busy=%b bg=%b", bus.bus_busy, bus.bg);
      else n_pass++;
    end
  end

  task automatic test_reset();
    @(negedge bus_clk);
    rst    = 1'b0;
    bus.br = 3'b111;
    #1;
    n_total++;
    if (bus.bg !== 3'b000) $display("FAIL reset_bg got=%b exp=000", bus.bg);
    else n_pass++;
    n_total++;
    if (bus.grant_id !== 3'd0) $display("FAIL reset_gid got=%0d exp=0", bus.grant_id);
    else n_pass++;
    n_total++;
    if (bus.bus_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.bus_busy);
    else n_pass++;
    n_total++;
    if (bus.timeout !== 1'b0) $display("FAIL reset_timeout got=%b exp=0", bus.timeout);
    else n_pass++;
    @(negedge bus_clk);
    rst = 1'b1;
    tick();
    n_total++;
    if (bus.bg !== 3'b001 || bus.grant_id !== 3'd0 || bus.bus_busy !== 1'b1)
      $display("FAIL reset_first_grant got bg=%b gid=%0d busy=%b exp bg=001 gid=0 busy=1",
               bus.bg, bus.grant_id, bus.bus_busy);
    else n_pass++;
  endtask

  task automatic test_rotation();
    logic [2:0] exp_bg;
    int         owner;
    do_reset(3'b111);
    for (int g = 0; g < 6; g++) begin
      owner  = g % 3;
      exp_bg = 3'b001 << owner;
      for (int c = 0; c < 4; c++) begin
        tick();
        n_total++;
        if (bus.bg !== exp_bg || bus.grant_id !== 3'(owner))
          $display("FAIL rotate_grant g=%0d c=%0d got bg=%b gid=%0d exp bg=%b gid=%0d",
                   g, c, bus.bg, bus.grant_id, exp_bg, owner);
        else n_pass++;
      end
      bus.br[owner] = 1'b0;
      tick();
      n_total++;
      if (bus.bg !== 3'b000) $display("FAIL rotate_gap1 g=%0d got=%b exp=000", g, bus.bg);
      else n_pass++;
      bus.br[owner] = 1'b1;
      tick();
      n_total++;
      if (bus.bg !== 3'b000) $display("FAIL rotate_gap2 g=%0d got=%b exp=000", g, bus.bg);
      else n_pass++;
    end
    bus.br = 3'b000;
  endtask

  task automatic test_single();
    do_reset(3'b000);
    bus.br = 3'b100;
    tick();
    n_total++;
    if (bus.bg !== 3'b100 || bus.grant_id !== 3'd2)
      $display("FAIL single_grant got bg=%b gid=%0d exp bg=100 gid=2", bus.bg, bus.grant_id);
    else n_pass++;
    bus.br = 3'b000;
    tick();
    n_total++;
    if (bus.bg !== 3'b000 || bus.bus_busy !== 1'b0)
      $display("FAIL single_release got bg=%b busy=%b exp bg=000 busy=0", bus.bg, bus.bus_busy);
    else n_pass++;
    // Pointer must have wrapped 2 -> 0, so master 0 beats master 1.
    bus.br = 3'b011;
    tick();
    tick();
    n_total++;
    if (bus.bg !== 3'b001 || bus.grant_id !== 3'd0)
      $display("FAIL ptr_wrap got bg=%b gid=%0d exp bg=001 gid=0", bus.bg, bus.grant_id);
    else n_pass++;
    bus.br = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    do_reset(3'b010);
    tick();
    bus.br = 3'b011;
    for (int c = 0; c < 8; c++) begin
      n_total++;
      if (bus.bg !== 3'b010 || bus.timeout !== 1'b0)
        $display("FAIL tenure_hold c=%0d got bg=%b to=%b exp bg=010 to=0", c, bus.bg, bus.timeout);
      else n_pass++;
      tick();
    end
    n_total++;
    if (bus.bg !== 3'b000 || bus.timeout !== 1'b1)
      $display("FAIL tenure_revoke got bg=%b to=%b exp bg=000 to=1", bus.bg, bus.timeout);
    else n_pass++;
    tick();
    n_total++;
    if (bus.bg !== 3'b000 || bus.timeout !== 1'b0)
      $display("FAIL tenure_pulse got bg=%b to=%b exp bg=000 to=0", bus.bg, bus.timeout);
    else n_pass++;
    tick();
    n_total++;
    if (bus.bg !== 3'b001 || bus.grant_id !== 3'd0)
      $display("FAIL tenure_next got bg=%b gid=%0d exp bg=001 gid=0", bus.bg, bus.grant_id);
    else n_pass++;
    bus.br = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_release_at_tenure();
    do_reset(3'b001);
    for (int c = 0; c < 8; c++) begin
      tick();
      n_total++;
      if (bus.bg !== 3'b001)
        $display("FAIL edge_hold c=%0d got bg=%b exp bg=001", c, bus.bg);
      else n_pass++;
    end
    bus.br = 3'b000;
    tick();
    n_total++;
    if (bus.bg !== 3'b000 || bus.timeout !== 1'b0)
      $display("FAIL edge_release got bg=%b to=%b exp bg=000 to=0", bus.bg, bus.timeout);
    else n_pass++;
    tick();
    n_total++;
    if (bus.timeout !== 1'b0) $display("FAIL edge_no_pulse got to=%b exp to=0", bus.timeout);
    else n_pass++;
  endtask

  task automatic test_reset_mid_grant();
    do_reset(3'b100);
    tick();
    n_total++;
    if (bus.grant_id !== 3'd2) $display("FAIL midrst_setup got gid=%0d exp gid=2", bus.grant_id);
    else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_total++;
    if (bus.bg !== 3'b000 || bus.bus_busy !== 1'b0 || bus.timeout !== 1'b0)
      $display("FAIL midrst_async got bg=%b busy=%b to=%b exp bg=000 busy=0 to=0",
               bus.bg, bus.bus_busy, bus.timeout);
    else n_pass++;
    bus.br = 3'b110;
    @(negedge bus_clk);
    rst = 1'b1;
    tick();
    n_total++;
    if (bus.bg !== 3'b010 || bus.grant_id !== 3'd1)
      $display("FAIL midrst_regrant got bg=%b gid=%0d exp bg=010 gid=1", bus.bg, bus.grant_id);
    else n_pass++;
    bus.br = 3'b000;
    tick();
    tick();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b0;
    bus.br  = 3'b000;
    test_reset();
    test_rotation();
    test_single();
    test_timeout();
    test_release_at_tenure();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
